// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and bus-side signal bundle of the OAM DMA arbiter.
// The slave modport is the arbiter; master is whoever drives the CPU port and owns the memory.
interface oam_dma_arbiter_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_rdata;
    logic        dma_active;
    logic [7:0]  dma_src_hi;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, bus_rdata,
        output cpu_rdata, bus_addr, bus_wdata, bus_rd, bus_wr, dma_active, dma_src_hi
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, bus_rdata,
        input  cpu_rdata, bus_addr, bus_wdata, bus_rd, bus_wr, dma_active, dma_src_hi
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// OAM DMA register and byte engine; shares one memory bus between the CPU and the DMA copy.
// During a transfer only HRAM stays reachable for the CPU; HRAM accesses stall the DMA.
module oam_dma_arbiter #(
    parameter int          DMA_LEN     = 160,
    parameter logic [15:0] DST_BASE    = 16'hFE00,
    parameter logic [15:0] REG_ADDR    = 16'hFF46,
    parameter int          START_DELAY = 1
) (
    input logic              clk,
    input logic              rst,
    oam_dma_arbiter_if.slave port
);

    localparam int              DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY - 1);
    localparam logic [7:0]      IDX_LAST = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    state_t           state;
    logic [7:0]       src_hi;
    logic [7:0]       idx;
    logic [7:0]       latch;
    logic [DLY_W-1:0] dly_cnt;

    logic cpu_wr_req, cpu_rd_req, cpu_acc;
    logic reg_hit, hram_hit, dma_phase, cpu_owns, dma_go;

    // A simultaneous read and write strobe is a write.
    assign cpu_wr_req = port.cpu_wr;
    assign cpu_rd_req = port.cpu_rd & ~port.cpu_wr;
    assign cpu_acc    = cpu_rd_req | cpu_wr_req;
    assign reg_hit    = (port.cpu_addr == REG_ADDR);
    assign hram_hit   = (port.cpu_addr >= 16'hFF80) && (port.cpu_addr <= 16'hFFFE);
    assign dma_phase  = (state == READ) || (state == WRITE);
    assign cpu_owns   = cpu_acc && !reg_hit && (!dma_phase || hram_hit);
    assign dma_go     = dma_phase && !(cpu_acc && hram_hit);

    assign port.dma_active = dma_phase;
    assign port.dma_src_hi = src_hi;

    always_comb begin
        port.bus_addr  = port.cpu_addr;
        port.bus_wdata = port.cpu_wdata;
        port.bus_rd    = 1'b0;
        port.bus_wr    = 1'b0;
        if (cpu_owns) begin
            port.bus_rd = cpu_rd_req;
            port.bus_wr = cpu_wr_req;
        end else if (dma_go) begin
            if (state == READ) begin
                port.bus_addr = {src_hi, idx};
                port.bus_rd   = 1'b1;
            end else begin
                port.bus_addr  = DST_BASE + {8'h00, idx};
                port.bus_wdata = latch;
                port.bus_wr    = 1'b1;
            end
        end
    end

    always_comb begin
        if (reg_hit)
            port.cpu_rdata = src_hi;
        else if (!dma_phase || hram_hit)
            port.cpu_rdata = port.bus_rdata;
        else
            port.cpu_rdata = 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            src_hi  <= 8'hFF;
            idx     <= 8'h00;
            latch   <= 8'h00;
            dly_cnt <= '0;
        end else begin
            case (state)
                START: begin
                    if (dly_cnt == DLY_LAST)
                        state <= READ;
                    else
                        dly_cnt <= dly_cnt + DLY_W'(1);
                end
                READ: begin
                    if (dma_go) begin
                        latch <= port.bus_rdata;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (dma_go) begin
                        if (idx == IDX_LAST) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= READ;
                        end
                    end
                end
                default: ;
            endcase
            // A register write restarts the engine after this cycle's bus op has been issued.
            if (cpu_wr_req && reg_hit) begin
                src_hi  <= port.cpu_wdata;
                idx     <= 8'h00;
                dly_cnt <= '0;
                state   <= START;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: per-cycle expectations from a transfer-list model feed a scoreboard queue.
// A negedge monitor pops each entry and compares the bus and CPU-facing outputs.
module tb_oam_dma_arbiter;

    localparam int          DMA_LEN     = 160;
    localparam int          START_DELAY = 1;
    localparam logic [15:0] DST         = 16'hFE00;
    localparam logic [15:0] REG         = 16'hFF46;

    logic clk = 1'b0;
    logic rst = 1'b1;

    oam_dma_arbiter_if dif ();

    oam_dma_arbiter #(
        .DMA_LEN(DMA_LEN), .DST_BASE(DST), .REG_ADDR(REG), .START_DELAY(START_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .port(dif.slave)
    );

    always #5 clk = ~clk;

    // External memory and the model's private copy, seeded with the same pattern.
    logic [7:0] tb_mem  [65536];
    logic [7:0] ref_mem [65536];

    function automatic logic [7:0] seed_byte(input int i);
        return 8'((i * 37) ^ ((i >> 8) * 11) ^ 8'h5A);
    endfunction

    assign dif.bus_rdata = tb_mem[dif.bus_addr];

    initial begin
        for (int i = 0; i < 65536; i++) tb_mem[i] = seed_byte(i);
        forever begin
            @(posedge clk);
            if (dif.bus_wr) tb_mem[dif.bus_addr] = dif.bus_wdata;
        end
    end

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          chk_rdata;
        logic [7:0]  rdata;
        bit          active;
        logic [7:0]  src;
    } exp_t;

    typedef struct {
        string name;
        int    got;
        int    exp;
    } spc_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
    } op_t;

    exp_t exp_q[$];
    spc_t spc_q[$];

    int checks  = 0;
    int errors  = 0;
    int act_cnt = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        spc_t s;
        act_cnt += int'(dif.dma_active);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bus_rd", 16'(dif.bus_rd), 16'(e.rd));
            chk("bus_wr", 16'(dif.bus_wr), 16'(e.wr));
            chk("dma_active", 16'(dif.dma_active), 16'(e.active));
            chk("dma_src_hi", 16'(dif.dma_src_hi), 16'(e.src));
            if (e.rd || e.wr) chk("bus_addr", dif.bus_addr, e.addr);
            if (e.wr) chk("bus_wdata", 16'(dif.bus_wdata), 16'(e.wdata));
            if (e.chk_rdata) chk("cpu_rdata", 16'(dif.cpu_rdata), 16'(e.rdata));
        end
        while (spc_q.size() != 0) begin
            s = spc_q.pop_front();
            checks++;
            if (s.got != s.exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", s.name, s.got, s.exp);
            end
        end
    end

    // Reference model: a pending list of DMA bus operations plus a start countdown.
    op_t        ops[$];
    int         dly_left = 0;
    logic [7:0] m_src    = 8'hFF;
    logic [7:0] m_latch  = 8'h00;

    task automatic model_step(input logic [15:0] a, input logic [7:0] d,
                              input bit r, input bit w, input bit rs);
        exp_t e;
        op_t  op;
        bit   rreq, acc, reg_hit, hram, dma;
        rreq    = r && !w;
        acc     = rreq || w;
        reg_hit = (a == REG);
        hram    = (a >= 16'hFF80) && (a <= 16'hFFFE);
        dma     = (ops.size() != 0) && (dly_left == 0);
        e = '{rd: 1'b0, wr: 1'b0, addr: 16'h0, wdata: 8'h0, chk_rdata: 1'b0,
              rdata: 8'h0, active: dma, src: m_src};
        if (acc && !reg_hit && (!dma || hram)) begin
            e.rd = rreq; e.wr = w; e.addr = a; e.wdata = d;
            if (rreq) begin e.chk_rdata = 1'b1; e.rdata = ref_mem[a]; end
            if (w) ref_mem[a] = d;
        end else if (dma) begin
            op = ops.pop_front();
            e.addr = op.addr;
            if (op.wr) begin
                e.wr = 1'b1; e.wdata = m_latch; ref_mem[op.addr] = m_latch;
            end else begin
                e.rd = 1'b1; m_latch = ref_mem[op.addr];
            end
        end
        if (rreq && reg_hit) begin
            e.chk_rdata = 1'b1; e.rdata = m_src;
        end else if (rreq && dma && !hram) begin
            e.chk_rdata = 1'b1; e.rdata = 8'hFF;
        end
        exp_q.push_back(e);
        if (!dma && ops.size() != 0 && dly_left > 0) dly_left--;
        if (w && reg_hit) begin
            m_src = d;
            ops.delete();
            for (int i = 0; i < DMA_LEN; i++) begin
                ops.push_back('{wr: 1'b0, addr: {d, 8'(i)}});
                ops.push_back('{wr: 1'b1, addr: DST + 16'(i)});
            end
            dly_left = START_DELAY;
        end
        if (rs) begin
            ops.delete(); m_src = 8'hFF; m_latch = 8'h00; dly_left = 0;
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d,
                       input bit r, input bit w, input bit rs);
        @(posedge clk);
        #1;
        dif.cpu_addr  = a;
        dif.cpu_wdata = d;
        dif.cpu_rd    = r;
        dif.cpu_wr    = w;
        rst           = rs;
        model_step(a, d, r, w, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_op();
        int          p, k;
        logic [15:0] a;
        logic [7:0]  d;
        p = $urandom_range(0, 99);
        k = $urandom_range(0, 2);
        d = 8'($urandom);
        if (p < 50) begin
            idle(1);
            return;
        end else if (p < 65) a = 16'hFF80 + 16'($urandom_range(0, 126));
        else if (p < 85) a = 16'($urandom);
        else if (p < 93) begin cyc(REG, d, 1'b1, 1'b0, 1'b0); return; end
        else if (p < 95) begin cyc(REG, d, 1'b0, 1'b1, 1'b0); return; end
        else a = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'hFF7F;
        cyc(a, d, (k != 1), (k != 0), 1'b0);
    endtask

    initial begin
        int s0, bad;
        dif.cpu_addr  = 16'h0;
        dif.cpu_wdata = 8'h0;
        dif.cpu_rd    = 1'b0;
        dif.cpu_wr    = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = seed_byte(i);

        cyc(16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        cyc(16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        idle(1);
        cyc(REG, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(REG, 8'hC1, 1'b0, 1'b1, 1'b0);
        cyc(REG, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(340);

        // Clean transfer from C000.
        s0 = act_cnt;
        cyc(REG, 8'hC0, 0, 1, 0);
        idle(340);
        spc_q.push_back('{name: "active_cycles_plain", got: act_cnt - s0, exp: 2 * DMA_LEN});

        // Blocked CPU accesses during a transfer.
        cyc(REG, 8'hC0, 0, 1, 0);
        idle(5);
        cyc(16'h0150, 8'h00, 1, 0, 0);
        cyc(16'hC100, 8'h55, 0, 1, 0);
        idle(340);
        spc_q.push_back('{name: "blocked_write_dropped", got: int'(tb_mem[16'hC100]),
                          exp: int'(seed_byte(16'hC100))});

        // HRAM read lands on the WRITE of byte 5 and stalls the engine one cycle.
        s0 = act_cnt;
        cyc(REG, 8'hC0, 0, 1, 0);
        idle(12);
        cyc(16'hFF80, 8'h00, 1, 0, 0);
        idle(340);
        spc_q.push_back('{name: "active_cycles_stall", got: act_cnt - s0, exp: 2 * DMA_LEN + 1});

        // Restart at the READ of byte 100.
        cyc(REG, 8'hC0, 0, 1, 0);
        idle(201);
        cyc(REG, 8'hD0, 0, 1, 0);
        idle(340);

        // Reset at the READ of byte 50.
        cyc(REG, 8'hC0, 0, 1, 0);
        idle(101);
        cyc(16'h0, 8'h0, 0, 0, 1);
        idle(20);

        for (int t = 0; t < 6; t++) begin
            cyc(REG, 8'($urandom), 0, 1, 0);
            for (int i = 0; i < 400; i++) rand_op();
            idle(340);
        end

        bad = 0;
        for (int i = 0; i < 65536; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        spc_q.push_back('{name: "memory_image", got: bad, exp: 0});
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the OAM DMA register (FF46) and the DMA byte engine.
- Arbitrates the single external memory bus between the CPU core's memory port and the DMA engine.
- A CPU write to FF46 copies DMA_LEN bytes from {src_hi, 8'h00} to DST_BASE, one bus operation per clk.
- Sits between the CPU core's address/data port and the system memory map.

Parameters:
- DMA_LEN, 160, number of bytes per transfer (1..256)
- DST_BASE, 16'hFE00, destination base address (OAM)
- REG_ADDR, 16'hFF46, DMA start/source register address
- START_DELAY, 1, clk cycles between the FF46 write and the first DMA read (>=1)

Ports:
- clk  in  1  system clock, one bus operation per cycle
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- cpu_rdata  out  8  CPU read data (combinational)
- bus_addr  out  16  external bus address
- bus_wdata  out  8  external bus write data
- bus_rd  out  1  external bus read strobe
- bus_wr  out  1  external bus write strobe
- bus_rdata  in  8  external bus read data, valid in the same cycle as bus_rd
- dma_active  out  1  DMA owns the bus (READ/WRITE states)
- dma_src_hi  out  8  current FF46 register value

Behaviour:
- Reset: state IDLE, dma_src_hi=8'hFF, byte index=0, data latch=0, dma_active=0. bus_rd/bus_wr are 0 because the CPU is idle after reset.
- CPU access to REG_ADDR is always handled internally and never forwarded to the bus:
  - read returns dma_src_hi.
  - write loads dma_src_hi <= cpu_wdata, clears the index, sets delay count=0, next state START.
- HRAM: cpu_addr in FF80..FFFE.
- Blocked access: any CPU access other than HRAM or REG_ADDR.
- If cpu_rd and cpu_wr are both high, the access is treated as a write; cpu_rd is ignored.
- States:
  - IDLE: CPU passthrough. bus_* mirror cpu_*; cpu_rdata=bus_rdata on read.
  - START: CPU passthrough. Delay counter increments each cycle; after START_DELAY cycles go to READ.
  - READ: if the CPU is accessing HRAM, the CPU gets the bus and DMA stalls (no state change). Otherwise bus_addr={dma_src_hi, idx[7:0]}, bus_rd=1, data latch <= bus_rdata at clk edge, next state WRITE.
  - WRITE: same HRAM stall rule. Otherwise bus_addr=DST_BASE+idx, bus_wr=1, bus_wdata=latch. If idx==DMA_LEN-1 go to IDLE, else idx++ and go to READ.
- In READ/WRITE:
  - Blocked CPU reads return 8'hFF; blocked CPU writes are dropped.
  - The DMA operation proceeds in that cycle.
- dma_active=1 exactly in READ and WRITE, including stalled cycles.
- Latency: with no stalls, the first DMA read occurs START_DELAY cycles after the FF46 write cycle. The transfer occupies 2*DMA_LEN cycles, and dma_active deasserts the cycle after the last write.
- Restart: an FF46 write during START/READ/WRITE still performs that cycle's DMA bus op. The next state is START with the new source and idx=0. The partially transferred byte is abandoned.
- Idle outputs: bus_wdata=cpu_wdata when the CPU owns the bus. With no bus owner strobe, bus_rd/bus_wr=0.
- Width: idx is 8 bits; DST_BASE+idx is 16-bit unsigned with no wrap handling required for legal parameters.
- Reset mid-transfer: immediate return to IDLE with reset values; no further DMA strobes.

Test Plan:
- Reset, CPU read FF46 -> cpu_rdata=8'hFF, no bus_rd; write 8'hC1 to FF46 then read -> 8'hC1.
- Write 8'hC0 to FF46, CPU idle -> after 1 START cycle, 160 read/write pairs: read C000 then write FE00 ... read C09F then write FE9F. Data matches the memory model; dma_active high for exactly 320 cycles.
- During DMA, CPU reads 0x0150 -> cpu_rdata=8'hFF with no CPU bus op; CPU writes 0xC100=8'h55 -> memory unchanged.
- During DMA WRITE of byte 5, CPU reads FF80 -> the CPU read is on the bus that cycle and returns HRAM data. The DMA write of byte 5 occurs on the next cycle; total duration is 321 cycles.
- At byte 100, write 8'hD0 to FF46 -> the current op completes, then START, then copy restarts from D000 to FE00 for 160 bytes.
- Assert rst mid-transfer at byte 50 -> next cycle: state IDLE, dma_active=0, dma_src_hi=8'hFF, no further DMA writes.
